// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - streaming 2x2 stride-2 max/average pooling engine
// Even rows fold column pairs into a half-width row buffer; odd rows finish each window.
module pool2d_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CH         = 1,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH*DATA_WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH*DATA_WIDTH-1:0]   out_data,
  output logic                       out_last
);
  localparam int DW     = DATA_WIDTH;
  localparam int PW     = DATA_WIDTH + 2;
  localparam int AW     = DATA_WIDTH + 3;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int HALF_W = IMG_W / 2;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  // One guard bit beyond the partial width keeps unsigned sums positive in signed math
  function automatic logic signed [AW-1:0] ext_s(input logic [DW-1:0] x);
    logic fill;
    fill = SIGNED ? x[DW-1] : 1'b0;
    return {{(AW-DW){fill}}, x};
  endfunction

  function automatic logic signed [AW-1:0] ext_p(input logic [PW-1:0] x);
    logic fill;
    fill = SIGNED ? x[PW-1] : 1'b0;
    return {{(AW-PW){fill}}, x};
  endfunction

  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 mode_q, mode_d;
  logic [CH*DW-1:0]     hold_q, hold_d;
  logic [CH*PW-1:0]     rowbuf_q [HALF_W];
  logic [CH*PW-1:0]     rowbuf_d [HALF_W];
  logic                 out_valid_q, out_valid_d;
  logic [CH*DW-1:0]     out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;

  logic                 in_fire;
  logic                 last_px;
  logic [IDX_W-1:0]     rb_idx;
  logic [CH*PW-1:0]     part;
  logic [CH*DW-1:0]     res;

  assign in_ready  = !out_valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign rb_idx    = IDX_W'(col_q >> 1);
  assign last_px   = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [AW-1:0] s_in, s_hold, s_rb, pair_max, quad_max, quad_sum;
    assign s_in     = ext_s(in_data[c*DW +: DW]);
    assign s_hold   = ext_s(hold_q[c*DW +: DW]);
    assign s_rb     = ext_p(rowbuf_q[rb_idx][c*PW +: PW]);
    assign pair_max = (s_in > s_hold) ? s_in : s_hold;
    assign quad_max = (pair_max > s_rb) ? pair_max : s_rb;
    assign quad_sum = s_rb + s_hold + s_in + AW'(2);
    assign part[c*PW +: PW] = mode_q ? PW'(s_hold + s_in) : PW'(pair_max);
    assign res[c*DW +: DW]  = mode_q ? DW'(quad_sum >>> 2) : DW'(quad_max);
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    hold_d      = hold_q;
    rowbuf_d    = rowbuf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (in_fire) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (col_q == '0 && row_q == '0) mode_d = mode;
      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (!row_q[0]) begin
        rowbuf_d[rb_idx] = part;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = res;
        out_last_d  = last_px;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    rowbuf_q <= rowbuf_d;
  end
endmodule

// File: tb/tb_pool2d_stream.sv
// tb/tb_pool2d_stream.sv - randomized self-checking bench for pool2d_stream
// Small 4x4 unsigned/signed pair plus a 3-channel 28x28 instance against an arithmetic model.
module tb_pool2d_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int num_checks = 0;
  int num_errors = 0;

  logic s_clear, s_mode, s_in_valid, s_out_ready;
  logic [7:0] s_in_data;
  logic u_in_ready, u_out_valid, u_out_last;
  logic [7:0] u_out_data;
  logic g_in_ready, g_out_valid, g_out_last;
  logic [7:0] g_out_data;
  logic b_clear, b_mode, b_in_valid, b_out_ready;
  logic [23:0] b_in_data;
  logic b_in_ready, b_out_valid, b_out_last;
  logic [23:0] b_out_data;

  pool2d_stream #(.DATA_WIDTH(8), .CH(1), .IMG_W(4), .IMG_H(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .mode(s_mode), .in_valid(s_in_valid),
    .in_ready(u_in_ready), .in_data(s_in_data), .out_valid(u_out_valid),
    .out_ready(s_out_ready), .out_data(u_out_data), .out_last(u_out_last));
  pool2d_stream #(.DATA_WIDTH(8), .CH(1), .IMG_W(4), .IMG_H(4), .SIGNED(1'b1)) dut_g (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .mode(s_mode), .in_valid(s_in_valid),
    .in_ready(g_in_ready), .in_data(s_in_data), .out_valid(g_out_valid),
    .out_ready(s_out_ready), .out_data(g_out_data), .out_last(g_out_last));
  pool2d_stream #(.DATA_WIDTH(8), .CH(3), .IMG_W(28), .IMG_H(28), .SIGNED(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .mode(b_mode), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last));

  logic [8:0]  u_q[$], g_q[$], u_exp[$], g_exp[$];
  logic [24:0] b_q[$], b_exp[$];
  logic [7:0]  sfrm [16];
  logic [23:0] bfrm [784];
  logic [7:0]  pxa [16];
  logic [7:0]  pxs [16];

  always @(negedge clk) begin
    if (u_out_valid && s_out_ready) u_q.push_back({u_out_last, u_out_data});
    if (g_out_valid && s_out_ready) g_q.push_back({g_out_last, g_out_data});
    if (b_out_valid && b_out_ready) b_q.push_back({b_out_last, b_out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sval(input logic [7:0] x, input bit sgn);
    return sgn ? int'($signed(x)) : int'(x);
  endfunction

  function automatic logic [7:0] pool4(input logic [7:0] a, b, c, d, input bit avg, input bit sgn);
    int v[4];
    int s, r;
    v[0] = sval(a, sgn); v[1] = sval(b, sgn); v[2] = sval(c, sgn); v[3] = sval(d, sgn);
    if (avg) begin
      s = v[0] + v[1] + v[2] + v[3] + 2;
      r = (s >= 0) ? s / 4 : -((3 - s) / 4);
    end else begin
      r = v[0];
      for (int k = 1; k < 4; k++) if (v[k] > r) r = v[k];
    end
    return r[7:0];
  endfunction

  task automatic build_exp_small(input bit avg);
    int base;
    logic l;
    for (int pr = 0; pr < 2; pr++) for (int pc = 0; pc < 2; pc++) begin
      base = pr * 8 + pc * 2;
      l = (pr == 1) && (pc == 1);
      u_exp.push_back({l, pool4(sfrm[base], sfrm[base+1], sfrm[base+4], sfrm[base+5], avg, 1'b0)});
      g_exp.push_back({l, pool4(sfrm[base], sfrm[base+1], sfrm[base+4], sfrm[base+5], avg, 1'b1)});
    end
  endtask

  task automatic build_exp_big(input bit avg);
    int base;
    logic l;
    logic [23:0] o;
    for (int pr = 0; pr < 14; pr++) for (int pc = 0; pc < 14; pc++) begin
      base = pr * 56 + pc * 2;
      l = (pr == 13) && (pc == 13);
      for (int ch = 0; ch < 3; ch++)
        o[ch*8 +: 8] = pool4(bfrm[base][ch*8 +: 8], bfrm[base+1][ch*8 +: 8],
                             bfrm[base+28][ch*8 +: 8], bfrm[base+29][ch*8 +: 8], avg, 1'b0);
      b_exp.push_back({l, o});
    end
  endtask

  task automatic drive_s(input logic [7:0] d, input logic md, input int gap);
    int n;
    logic ok;
    s_in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_in_valid = 1'b1; s_in_data = d; s_mode = md;
    n = 0;
    forever begin
      @(negedge clk); ok = u_in_ready;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 300) begin check("s_accept", {31'b0, ok}, 32'd1); break; end
    end
    s_in_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [23:0] d, input logic md, input int gap);
    int n;
    logic ok;
    b_in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    b_in_valid = 1'b1; b_in_data = d; b_mode = md;
    n = 0;
    forever begin
      @(negedge clk); ok = b_in_ready;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 300) begin check("b_accept", {31'b0, ok}, 32'd1); break; end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic compare_small(input string tag);
    int n;
    s_out_ready = 1'b1;
    n = 0;
    while ((u_q.size() < u_exp.size() || g_q.size() < g_exp.size()) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_u_cnt"}, u_q.size(), u_exp.size());
    check({tag, "_g_cnt"}, g_q.size(), g_exp.size());
    for (int k = 0; k < u_exp.size() && k < u_q.size(); k++) check({tag, "_u_beat"}, u_q[k], u_exp[k]);
    for (int k = 0; k < g_exp.size() && k < g_q.size(); k++) check({tag, "_g_beat"}, g_q[k], g_exp[k]);
  endtask

  task automatic stream_small(input bit avg, input int gmax, input bit rand_rdy);
    bit done;
    for (int k = 0; k < 16; k++) sfrm[k] = 8'($urandom);
    u_q.delete(); g_q.delete(); u_exp.delete(); g_exp.delete();
    build_exp_small(avg);
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 16; k++)
          drive_s(sfrm[k], (k == 0) ? avg : 1'($urandom), $urandom_range(0, gmax));
        done = 1'b1;
      end
      begin
        while (!done) begin
          s_out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
          @(posedge clk); #1;
        end
      end
    join
    compare_small("s");
  endtask

  task automatic stream_big(input int nframes, input bit mode0);
    bit done;
    bit avg;
    int n;
    b_q.delete(); b_exp.delete();
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < nframes; f++) begin
          avg = mode0 ^ f[0];
          for (int k = 0; k < 784; k++) bfrm[k] = 24'($urandom);
          build_exp_big(avg);
          for (int k = 0; k < 784; k++)
            drive_b(bfrm[k], (k == 0) ? avg : 1'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          b_out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    b_out_ready = 1'b1;
    n = 0;
    while (b_q.size() < b_exp.size() && n < 50) begin @(posedge clk); #1; n++; end
    check("b_cnt", b_q.size(), b_exp.size());
    for (int k = 0; k < b_exp.size() && k < b_q.size(); k++) begin
      check("b_data", {8'b0, b_q[k][23:0]}, {8'b0, b_exp[k][23:0]});
      check("b_last", {31'b0, b_q[k][24]}, {31'b0, b_exp[k][24]});
    end
  endtask

  // Continuous stream with out_ready=1: every output must appear one cycle after its 4th pixel
  task automatic run_dir(input logic [7:0] px [16], input bit avg);
    logic ev, el;
    logic [7:0] eu, eg;
    s_out_ready = 1'b1;
    ev = 1'b0; el = 1'b0; eu = '0; eg = '0;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        s_in_valid = 1'b1; s_in_data = px[i]; s_mode = (i == 0) ? avg : !avg;
      end else begin
        s_in_valid = 1'b0;
      end
      @(negedge clk);
      check("dir_u_valid", {31'b0, u_out_valid}, {31'b0, ev});
      check("dir_g_valid", {31'b0, g_out_valid}, {31'b0, ev});
      if (ev) begin
        check("dir_u_data", {24'b0, u_out_data}, {24'b0, eu});
        check("dir_g_data", {24'b0, g_out_data}, {24'b0, eg});
        check("dir_u_last", {31'b0, u_out_last}, {31'b0, el});
        check("dir_g_last", {31'b0, g_out_last}, {31'b0, el});
      end
      if (i < 16) begin
        check("dir_u_ready", {31'b0, u_in_ready}, 32'd1);
        check("dir_g_ready", {31'b0, g_in_ready}, 32'd1);
        ev = (((i / 4) % 2) == 1) && (((i % 4) % 2) == 1);
        if (ev) begin
          eu = pool4(px[i-5], px[i-4], px[i-1], px[i], avg, 1'b0);
          eg = pool4(px[i-5], px[i-4], px[i-1], px[i], avg, 1'b1);
          el = (i == 15);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic bp_test();
    logic [7:0] held;
    int n;
    for (int k = 0; k < 16; k++) sfrm[k] = 8'($urandom);
    u_q.delete(); g_q.delete(); u_exp.delete(); g_exp.delete();
    build_exp_small(1'b0);
    s_out_ready = 1'b0;
    fork
      for (int k = 0; k < 16; k++) drive_s(sfrm[k], (k == 0) ? 1'b0 : 1'($urandom), 0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!u_out_valid && n < 100);
        check("bp_valid", {31'b0, u_out_valid}, 32'd1);
        held = u_out_data;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", {31'b0, u_in_ready}, 32'd0);
          check("bp_hold", {24'b0, u_out_data}, {24'b0, held});
        end
        @(posedge clk); #1;
        s_out_ready = 1'b1;
        repeat (4) begin @(negedge clk); check("bp_resume", {31'b0, u_in_ready}, 32'd1); end
        @(posedge clk); #1;
      end
    join
    compare_small("bp");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_clear = 1'b0; s_mode = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
    b_clear = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    pxa = '{8'd1, 8'd9, 8'd2, 8'd3, 8'd4, 8'd5, 8'd8, 8'd0,
            8'd7, 8'd7, 8'd7, 8'd7, 8'd0, 8'd255, 8'd1, 8'd6};
    pxs = '{8'hFF, 8'hFE, 8'h80, 8'hFB, 8'hFF, 8'hFE, 8'h9C, 8'hF9,
            8'h10, 8'hF0, 8'h7F, 8'h81, 8'h22, 8'h33, 8'h01, 8'h02};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_u_valid", {31'b0, u_out_valid}, 32'd0);
    check("rst_u_data", {24'b0, u_out_data}, 32'd0);
    check("rst_u_last", {31'b0, u_out_last}, 32'd0);
    check("rst_b_valid", {31'b0, b_out_valid}, 32'd0);
    check("rst_b_data", {8'b0, b_out_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_u_ready", {31'b0, u_in_ready}, 32'd1);
    check("rst_b_ready", {31'b0, b_in_ready}, 32'd1);
    @(posedge clk); #1;

    run_dir(pxa, 1'b0);
    run_dir(pxa, 1'b1);
    run_dir(pxs, 1'b1);
    run_dir(pxs, 1'b0);
    stream_small(1'b0, 3, 1'b1);
    stream_small(1'b1, 3, 1'b1);
    bp_test();

    s_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) drive_s(8'($urandom), 1'b0, 0);
    s_out_ready = 1'b0;
    drive_s(8'($urandom), 1'b0, 0);
    s_in_valid = 1'b1; s_in_data = 8'($urandom); s_clear = 1'b1;
    @(negedge clk);
    check("clr_pending", {31'b0, u_out_valid}, 32'd1);
    @(posedge clk); #1;
    s_clear = 1'b0; s_in_valid = 1'b0;
    @(negedge clk);
    check("clr_valid", {31'b0, u_out_valid}, 32'd0);
    check("clr_last", {31'b0, u_out_last}, 32'd0);
    check("clr_ready", {31'b0, u_in_ready}, 32'd1);
    @(posedge clk); #1;
    stream_small(1'b1, 2, 1'b1);

    b_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) drive_b(24'($urandom), 1'b0, 0);
    b_in_valid = 1'b1; b_in_data = 24'($urandom); b_clear = 1'b1;
    @(negedge clk);
    check("clr_b_ready", {31'b0, b_in_ready}, 32'd1);
    @(posedge clk); #1;
    b_clear = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    check("clr_b_valid", {31'b0, b_out_valid}, 32'd0);
    @(posedge clk); #1;
    stream_big(1, 1'b1);

    b_out_ready = 1'b0;
    for (int k = 0; k < 30; k++) drive_b(24'($urandom), 1'b0, 0);
    @(negedge clk);
    check("rst_b_pending", {31'b0, b_out_valid}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, b_out_valid}, 32'd0);
    check("arst_data", {8'b0, b_out_data}, 32'd0);
    check("arst_last", {31'b0, b_out_last}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", {31'b0, b_in_ready}, 32'd1);
    @(posedge clk); #1;
    stream_big(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end
endmodule
